lmc_control_fsm: RTL and testbench

Multicycle control unit that drives the 4-bit ALUControl/zero interface of the 64-bit LEGv8 ALU, plus the datapath's mux, register-file and memory enables. It sits between the instruction register (opcode field) and the shared multicycle datapath. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and stalls on a memory ready handshake. It replaces the single-cycle combinational decoder when the core runs with one shared memory port.

---
 rtl/lmc_control_fsm_if.sv | 32 +++
 rtl/lmc_control_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_lmc_control_fsm.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lmc_control_fsm_if.sv
// Control/datapath bundle between lmc_control_fsm (master) and the multicycle LEGv8 datapath (slave).
interface lmc_control_fsm_if;
    logic [10:0] Op;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  ALUControl;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        PCSrc;
    logic        MemtoReg;
    logic        Reg2Loc;
    logic        exc;
    logic [3:0]  state_o;

    modport master (
        input  Op, zero, mem_ready,
        output ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, RegWrite, PCSrc, MemtoReg, Reg2Loc, exc, state_o
    );

    modport slave (
        output Op, zero, mem_ready,
        input  ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, RegWrite, PCSrc, MemtoReg, Reg2Loc, exc, state_o
    );
endinterface

// File: rtl/lmc_control_fsm.sv
// Multicycle LEGv8 control FSM with memory-ready stalls; state_o codes FETCH=0 .. JUMP=9, EXC=10.
// Optional LMC_ILLEGAL_TRAP_EN: undecoded opcodes trap into a sticky EXC state instead of acting as NOPs.
module lmc_control_fsm (
    input  logic              clk,
    input  logic              reset,
    lmc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_RWB      = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
`ifdef LMC_ILLEGAL_TRAP_EN
        , S_EXC    = 4'd10
`endif
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    state_t      state;
    state_t      next;

    logic        is_r;
    logic        is_ldur;
    logic        is_stur;
    logic        is_cbz;
    logic        is_b;
    logic [3:0]  r_alu;

    logic [3:0]  alu;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        pc_src;
    logic        mem_to_reg;
    logic        reg2loc;
    logic        exc_flag;

    always_comb begin
        is_r    = 1'b0;
        is_ldur = 1'b0;
        is_stur = 1'b0;
        is_cbz  = 1'b0;
        is_b    = 1'b0;
        r_alu   = ALU_ADD;
        casez (bus.Op)
            11'b10001011000: begin is_r = 1'b1; r_alu = ALU_ADD; end
            11'b11001011000: begin is_r = 1'b1; r_alu = ALU_SUB; end
            11'b10001010000: begin is_r = 1'b1; r_alu = ALU_AND; end
            11'b10101010000: begin is_r = 1'b1; r_alu = ALU_ORR; end
            11'b11111000010: is_ldur = 1'b1;
            11'b11111000000: is_stur = 1'b1;
            11'b10110100???: is_cbz  = 1'b1;
            11'b000101?????: is_b    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next       = state;
        alu        = ALU_AND;
        src_a      = 2'b00;
        src_b      = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        exc_flag   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'b01;
                alu      = ALU_ADD;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                if (bus.mem_ready) next = S_DECODE;
            end
            S_DECODE: begin
                // Compute the branch target now so BRANCH/JUMP can load it from ALUOut.
                src_a   = 2'b01;
                src_b   = 2'b11;
                alu     = ALU_ADD;
                reg2loc = is_stur | is_cbz;
                if (is_r)                  next = S_EXEC_R;
                else if (is_ldur | is_stur) next = S_MEM_ADDR;
                else if (is_cbz)           next = S_BRANCH;
                else if (is_b)             next = S_JUMP;
`ifdef LMC_ILLEGAL_TRAP_EN
                else                       next = S_EXC;
`else
                else                       next = S_FETCH;
`endif
            end
            S_EXEC_R: begin
                src_a = 2'b10;
                src_b = 2'b00;
                alu   = r_alu;
                next  = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                src_a = 2'b10;
                src_b = 2'b10;
                alu   = ALU_ADD;
                if (is_stur)      next = S_MEM_WR;
                else if (is_ldur) next = S_MEM_RD;
                else              next = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                reg2loc   = 1'b1;
                if (bus.mem_ready) next = S_FETCH;
            end
            S_BRANCH: begin
                src_b    = 2'b00;
                reg2loc  = 1'b1;
                alu      = ALU_PASS;
                pc_src   = 1'b1;
                pc_write = bus.zero;
                next     = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                next     = S_FETCH;
            end
`ifdef LMC_ILLEGAL_TRAP_EN
            S_EXC: begin
                exc_flag = 1'b1;
                next     = S_EXC;
            end
`endif
            default: next = S_FETCH;
        endcase

        // Reset gates every output combinationally so an in-flight strobe drops in the reset cycle.
        if (!reset) begin
            alu        = '0;
            src_a      = '0;
            src_b      = '0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            pc_src     = 1'b0;
            mem_to_reg = 1'b0;
            reg2loc    = 1'b0;
            exc_flag   = 1'b0;
        end
    end

    assign bus.ALUControl = alu;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.IorD       = i_or_d;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.RegWrite   = reg_write;
    assign bus.PCSrc      = pc_src;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.Reg2Loc    = reg2loc;
    assign bus.exc        = exc_flag;
    assign bus.state_o    = reset ? state : S_FETCH;

endmodule

// File: tb/tb_lmc_control_fsm.sv
// Scoreboard bench for lmc_control_fsm: random instruction stream with random memory waits.
module tb_lmc_control_fsm;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       pcs;
    logic       m2r;
    logic       r2l;
    logic       exc;
    logic [3:0] st;
  } exp_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_RWB = 3, P_MEM_ADDR = 4,
                 P_MEM_RD = 5, P_MEM_WB = 6, P_MEM_WR = 7, P_BRANCH = 8, P_JUMP = 9, P_EXC = 10;
  localparam int C_R = 0, C_LDUR = 1, C_STUR = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  logic clk;
  logic reset;
  lmc_control_fsm_if bus ();

  lmc_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string what);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s t=%0t state_o=%0d MemRead=%b MemWrite=%b RegWrite=%b", what, $time,
               bus.state_o, bus.MemRead, bus.MemWrite, bus.RegWrite);
    end
  endtask

  function automatic int op_class(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LDUR;
    if (op == 11'b11111000000) return C_STUR;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [3:0] r_op_alu(input logic [10:0] op);
    if (op == 11'b11001011000) return 4'b0110;
    if (op == 11'b10001010000) return 4'b0000;
    if (op == 11'b10101010000) return 4'b0001;
    return 4'b0010;
  endfunction

  function automatic exp_t phase_exp(input int ph, input logic [10:0] op,
                                     input logic z, input logic rdy);
    exp_t e;
    int   c;
    e    = '0;
    e.st = 4'(ph);
    c    = op_class(op);
    case (ph)
      P_FETCH:    begin e.mr = 1'b1; e.sb = 2'b01; e.alu = 4'b0010; e.irw = rdy; e.pcw = rdy; end
      P_DECODE:   begin e.sa = 2'b01; e.sb = 2'b11; e.alu = 4'b0010;
                        e.r2l = (c == C_STUR || c == C_CBZ); end
      P_EXEC_R:   begin e.sa = 2'b10; e.sb = 2'b00; e.alu = r_op_alu(op); end
      P_RWB:      e.rw = 1'b1;
      P_MEM_ADDR: begin e.sa = 2'b10; e.sb = 2'b10; e.alu = 4'b0010; end
      P_MEM_RD:   begin e.mr = 1'b1; e.iord = 1'b1; end
      P_MEM_WB:   begin e.rw = 1'b1; e.m2r = 1'b1; end
      P_MEM_WR:   begin e.mw = 1'b1; e.iord = 1'b1; e.r2l = 1'b1; end
      P_BRANCH:   begin e.r2l = 1'b1; e.alu = 4'b0111; e.pcs = 1'b1; e.pcw = z; end
      P_JUMP:     begin e.pcw = 1'b1; e.pcs = 1'b1; end
      P_EXC:      e.exc = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input int ph, input logic [10:0] op, input logic z,
                     input logic rdy, input logic rst_n);
    reset         = rst_n;
    bus.Op        = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    if (rst_n) q.push_back(phase_exp(ph, op, z, rdy));
    else       q.push_back('0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] make_op(input int kind);
    logic [10:0] op;
    case (kind)
      0: op = 11'b10001011000;
      1: op = 11'b11001011000;
      2: op = 11'b10001010000;
      3: op = 11'b10101010000;
      4: op = 11'b11111000010;
      5: op = 11'b11111000000;
      6: op = {8'b10110100, 3'($urandom)};
      7: op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (op_class(op) != C_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  task automatic do_fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(P_FETCH, 11'($urandom), rbit(), 1'b0, 1'b1);
    cyc(P_FETCH, 11'($urandom), rbit(), 1'b1, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(P_FETCH, 11'($urandom), rbit(), rbit(), 1'b0);
  endtask

  task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input logic z);
    int c;
    c = op_class(op);
    do_fetch(fw);
    cyc(P_DECODE, op, rbit(), rbit(), 1'b1);
    case (c)
      C_R: begin
        cyc(P_EXEC_R, op, rbit(), rbit(), 1'b1);
        cyc(P_RWB, op, rbit(), rbit(), 1'b1);
      end
      C_LDUR: begin
        cyc(P_MEM_ADDR, op, rbit(), rbit(), 1'b1);
        for (int i = 0; i < mw; i++) cyc(P_MEM_RD, op, rbit(), 1'b0, 1'b1);
        cyc(P_MEM_RD, op, rbit(), 1'b1, 1'b1);
        cyc(P_MEM_WB, op, rbit(), rbit(), 1'b1);
      end
      C_STUR: begin
        cyc(P_MEM_ADDR, op, rbit(), rbit(), 1'b1);
        for (int i = 0; i < mw; i++) cyc(P_MEM_WR, op, rbit(), 1'b0, 1'b1);
        cyc(P_MEM_WR, op, rbit(), 1'b1, 1'b1);
      end
      C_CBZ: cyc(P_BRANCH, op, z, rbit(), 1'b1);
      C_B:   cyc(P_JUMP, op, rbit(), rbit(), 1'b1);
      default: begin
`ifdef LMC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) cyc(P_EXC, 11'($urandom), rbit(), rbit(), 1'b1);
        do_reset(1);
`endif
      end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = '{alu: bus.ALUControl, sa: bus.ALUSrcA, sb: bus.ALUSrcB, iord: bus.IorD,
            mr: bus.MemRead, mw: bus.MemWrite, irw: bus.IRWrite, pcw: bus.PCWrite,
            rw: bus.RegWrite, pcs: bus.PCSrc, m2r: bus.MemtoReg, r2l: bus.Reg2Loc,
            exc: bus.exc, st: bus.state_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctrl_word t=%0t state_exp=%0d got=%h exp=%h (alu,sa,sb,iord,mr,mw,irw,pcw,rw,pcs,m2r,r2l,exc,st)",
                 $time, e.st, a, e);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.Op        = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    chk(bus.state_o === 4'(P_FETCH) && bus.ALUControl === 4'b0000 && bus.ALUSrcA === 2'b00 &&
        bus.ALUSrcB === 2'b00 && bus.IorD === 1'b0 && bus.MemRead === 1'b0 &&
        bus.MemWrite === 1'b0 && bus.IRWrite === 1'b0 && bus.PCWrite === 1'b0 &&
        bus.RegWrite === 1'b0 && bus.PCSrc === 1'b0 && bus.MemtoReg === 1'b0 &&
        bus.Reg2Loc === 1'b0 && bus.exc === 1'b0, "reset_state");
    do_reset(3);

    run_instr(11'b10001011000, 0, 0, 1'b0);
    run_instr(11'b11111000010, 2, 3, 1'b0);
    chk(bus.state_o === 4'(P_FETCH) && bus.MemRead === 1'b1 && bus.RegWrite === 1'b0 &&
        bus.MemtoReg === 1'b0, "expired_wait");
    run_instr(11'b10110100101, 0, 0, 1'b1);
    run_instr(11'b10110100010, 0, 0, 1'b0);
    run_instr(11'b11111000000, 0, 0, 1'b0);
    run_instr(11'b00010110011, 0, 0, 1'b0);
    run_instr(11'b11111111111, 0, 0, 1'b0);

    run_instr(11'b10001010000, 1, 0, 1'b0);
    do_fetch(0);
    cyc(P_DECODE, 11'b11111000000, 1'b0, 1'b0, 1'b1);
    cyc(P_MEM_ADDR, 11'b11111000000, 1'b0, 1'b0, 1'b1);
    cyc(P_MEM_WR, 11'b11111000000, 1'b0, 1'b0, 1'b1);
    cyc(P_MEM_WR, 11'b11111000000, 1'b0, 1'b0, 1'b0);
    chk(bus.MemWrite === 1'b0 && bus.state_o === 4'(P_FETCH), "reset_mid_store");
    cyc(P_FETCH, 11'b11111000000, 1'b0, 1'b0, 1'b1);
    cyc(P_FETCH, 11'b11111000000, 1'b0, 1'b1, 1'b1);
    cyc(P_DECODE, 11'b10101010000, 1'b0, 1'b1, 1'b1);
    cyc(P_EXEC_R, 11'b10101010000, 1'b0, 1'b0, 1'b1);
    cyc(P_RWB, 11'b10101010000, 1'b0, 1'b1, 1'b1);

    for (int unsigned n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 8));
      if (kind == 8 && $urandom_range(0, 3) != 0) kind = int'($urandom_range(0, 7));
      run_instr(make_op(kind), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rbit());
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
